decode_ctrl_stage: RTL

//  Registered decode stage between fetch and execute. It decodes each accepted RV32I instruction

---
 rtl/riscv_pkg.sv | 64 ++++++
 rtl/decode_ctrl_stage_if.sv | 31 +++
 rtl/instr_decoder.sv | 97 +++++++++
 rtl/decode_ctrl_stage.sv | 118 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32I decode-stage types: control bundle, ALU/MD encodings, opcode and funct7 constants.
package riscv_pkg;

    localparam int unsigned CTRL_W = 19;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;

    typedef struct packed {
        logic       reg_write;
        logic [3:0] alu_ctrl;
        logic [1:0] alu_src_a;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       md_en;
        logic [2:0] md_op;
        logic       illegal;
    } ctrl_t;

    // ALU op for R/I arithmetic; alt selects SUB (funct3=000) or SRA (funct3=101)
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Fetch-side and EX-side handshake bundle of the decode stage.
interface decode_ctrl_stage_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    ctrl_t            out_ctrl;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  out_pc;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_instr, out_pc, occupancy
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_instr, out_pc, occupancy
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32I instruction decoder; RV32M decode enabled by macro RV32M_EN.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl_c
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal_c;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // Opcode decode; illegal encodings collapse to a bundle carrying only the illegal flag
    always_comb begin
        ctrl_c    = '0;
        illegal_c = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_ctrl  = alu_from_f3(funct3, funct7[5]);
                end
`ifdef RV32M_EN
                else if (funct7 == F7_MULDIV) begin
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_ctrl  = ALU_ADD;
                    ctrl_c.md_en     = 1'b1;
                    ctrl_c.md_op     = funct3;
                end
`endif
                else begin
                    illegal_c = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_ctrl  = alu_from_f3(funct3, funct7[5] & (funct3 == 3'b101));
            end
            OPC_LOAD: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_to_reg = 2'b01;
                ctrl_c.alu_ctrl   = ALU_ADD;
            end
            OPC_STORE: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_ctrl  = ALU_ADD;
            end
            OPC_BRANCH: begin
                ctrl_c.branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   ctrl_c.alu_ctrl = ALU_SUB;
                    2'b10:   ctrl_c.alu_ctrl = ALU_SLT;
                    2'b11:   ctrl_c.alu_ctrl = ALU_SLTU;
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.jump       = 1'b1;
                ctrl_c.mem_to_reg = 2'b10;
            end
            OPC_JALR: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.jalr       = 1'b1;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_to_reg = 2'b10;
                ctrl_c.alu_ctrl   = ALU_ADD;
            end
            OPC_LUI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src_a = 2'b10;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_ctrl  = ALU_ADD;
            end
            OPC_AUIPC: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src_a = 2'b01;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_ctrl  = ALU_ADD;
            end
            default: illegal_c = 1'b1;
        endcase
        if (illegal_c) begin
            ctrl_c         = '0;
            ctrl_c.illegal = 1'b1;
        end
    end
endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode stage: decodes accepted instructions and buffers {ctrl, instr, pc} in a DEPTH-entry FIFO.
// Optional RV32M decode is enabled by defining RV32M_EN.
module decode_ctrl_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_ctrl_stage_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} occ_state_e;

    occ_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             push_c;
    logic             pop_c;
    ctrl_t            dec_ctrl_c;

    ctrl_t            ctrl_mem  [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];

    instr_decoder u_dec (
        .instr  (bus.in_instr),
        .ctrl_c (dec_ctrl_c)
    );

    assign push_c = bus.in_valid & in_ready_q & ~bus.flush;
    assign pop_c  = out_valid_q & bus.out_ready & ~bus.flush;

    // Occupancy FSM next state, count and pointer updates; flush wins over push/pop
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            state_d  = S_EMPTY;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case (state_q)
                S_EMPTY: begin
                    if (push_c) begin
                        count_d = CNT_W'(1);
                        state_d = S_PARTIAL;
                    end
                end
                S_PARTIAL: begin
                    if (push_c && !pop_c) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_d == CNT_W'(DEPTH)) state_d = S_FULL;
                    end else if (pop_c && !push_c) begin
                        count_d = count_q - CNT_W'(1);
                        if (count_d == '0) state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop_c) begin
                        count_d = count_q - CNT_W'(1);
                        state_d = S_PARTIAL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, pointers and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= (state_d != S_FULL);
            out_valid_q <= (state_d != S_EMPTY);
        end
    end

    // Entry storage; contents are don't-care while not counted as occupied
    always_ff @(posedge clk) begin
        if (push_c) begin
            ctrl_mem[wr_ptr_q]  <= dec_ctrl_c;
            instr_mem[wr_ptr_q] <= bus.in_instr;
            pc_mem[wr_ptr_q]    <= bus.in_pc;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = out_valid_q ? ctrl_mem[rd_ptr_q]  : '0;
    assign bus.out_instr = out_valid_q ? instr_mem[rd_ptr_q] : '0;
    assign bus.out_pc    = out_valid_q ? pc_mem[rd_ptr_q]    : '0;
    assign bus.occupancy = count_q;
endmodule
